// File: rtl/ras_ctrl_pkg.sv
// Shared types and constants for the return-address-stack controller.
//
// Contents:
//   ras_op_t          one staged RAS operation (push, pop, checkpoint, address)
//   ras_ctrl_state_t  controller FSM states (RUN, FLUSH)
//   LINK_REG_X1/X5    RISC-V link registers used by the RAS hint rules
//   is_link_reg()     true when a register index is a link register
package cva5_types;

    typedef struct packed {
        logic        push;
        logic        pop;
        logic        branch_fetched;
        logic [31:0] new_addr;
    } ras_op_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ras_ctrl_state_t;

    localparam logic [4:0] LINK_REG_X1 = 5'd1;
    localparam logic [4:0] LINK_REG_X5 = 5'd5;

    function automatic logic is_link_reg(input logic [4:0] reg_addr);
        return (reg_addr == LINK_REG_X1) || (reg_addr == LINK_REG_X5);
    endfunction

endpackage

// File: rtl/ras_ctrl_op_decode.sv
// ras_op_decode: combinational RAS classification of one fetch instruction.
//
// Ports:
//   is_jal, is_jalr     control-flow kind
//   is_branch           instruction needs an RAS checkpoint
//   is_compressed       16-bit encoding (return address = pc + 2)
//   rd_addr, rs1_addr   register indices used by the link-register hints
//   pc                  instruction PC
//   op                  decoded push/pop/checkpoint and return address
module ras_op_decode
    import cva5_types::*;
(
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_branch,
    input  logic        is_compressed,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [31:0] pc,
    output ras_op_t     op
);

    logic rd_link_s;
    logic rs1_link_s;

    assign rd_link_s  = is_link_reg(rd_addr);
    assign rs1_link_s = is_link_reg(rs1_addr);

    // Link-register hint classification and return-address computation.
    always_comb begin
        op                = '0;
        op.branch_fetched = is_branch;
        op.new_addr       = pc + (is_compressed ? 32'd2 : 32'd4);
        if (is_jal) begin
            op.push = rd_link_s;
            op.pop  = 1'b0;
        end else if (is_jalr) begin
            // A JALR with rd==rs1 (both link) is a plain call: push only.
            op.push = rd_link_s;
            op.pop  = rs1_link_s & (~rd_link_s | (rd_addr != rs1_addr));
        end else begin
            op.push = 1'b0;
            op.pop  = 1'b0;
        end
    end

endmodule

// File: rtl/ras_ctrl.sv
// ras_ctrl: return-address-stack controller between fetch decode and the RAS.
//
// Classifies each accepted instruction into RAS push/pop, registers the
// operation for one cycle, limits in-flight checkpointed branches to MAX_IDS
// and quiesces RAS traffic for one cycle after any flush.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   fetch_valid / fetch_ready       instruction handshake
//   is_jal, is_jalr, is_branch,
//   is_compressed, rd_addr,
//   rs1_addr, pc                    decoded instruction fields
//   branch_retire                   oldest checkpointed branch retired
//   fetch_flush, early_flush        flush requests
//   ras_push, ras_pop, ras_new_addr registered RAS operation
//   ras_branch_fetched              registered checkpoint push
//   ras_branch_retired              combinational copy of branch_retire
//
// Optional feature: define RAS_UNDERFLOW_GUARD_EN to suppress pops while the
// occupancy estimate is zero.
module ras_ctrl
    import cva5_types::*;
#(
    parameter int RAS_ENTRIES = 8,
    parameter int MAX_IDS     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        is_branch,
    input  logic        is_compressed,
    input  logic [4:0]  rd_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [31:0] pc,
    input  logic        branch_retire,
    input  logic        fetch_flush,
    input  logic        early_flush,
    output logic        ras_push,
    output logic        ras_pop,
    output logic [31:0] ras_new_addr,
    output logic        ras_branch_fetched,
    output logic        ras_branch_retired
);

    localparam int IW = $clog2(MAX_IDS + 1);
    localparam int OW = $clog2(RAS_ENTRIES + 1);

    ras_ctrl_state_t state_r;
    ras_ctrl_state_t state_next_s;
    ras_op_t         dec_op_s;
    ras_op_t         guarded_op_s;
    ras_op_t         stage_r;
    ras_op_t         stage_next_s;
    logic [IW-1:0]   inflight_r;
    logic [IW-1:0]   inflight_next_s;
    logic [IW:0]     inflight_sum_s;
    logic [OW-1:0]   occ_r;
    logic [OW-1:0]   occ_next_s;
    logic            flush_s;
    logic            accept_s;

    ras_op_decode u_decode (
        .is_jal        (is_jal),
        .is_jalr       (is_jalr),
        .is_branch     (is_branch),
        .is_compressed (is_compressed),
        .rd_addr       (rd_addr),
        .rs1_addr      (rs1_addr),
        .pc            (pc),
        .op            (dec_op_s)
    );

    assign flush_s  = fetch_flush | early_flush;
    assign accept_s = fetch_valid & fetch_ready;

    // The staged checkpoint counts against the limit before it reaches inflight.
    assign inflight_sum_s = {1'b0, inflight_r} + {{IW{1'b0}}, stage_r.branch_fetched};
    assign fetch_ready    = (state_r == RUN) & (inflight_sum_s < (IW + 1)'(MAX_IDS));

    assign ras_push           = stage_r.push;
    assign ras_pop            = stage_r.pop;
    assign ras_new_addr       = stage_r.new_addr;
    assign ras_branch_fetched = stage_r.branch_fetched;
    assign ras_branch_retired = branch_retire;

    // Optional underflow guard; occ_r already includes every staged op.
    always_comb begin
        guarded_op_s = dec_op_s;
`ifdef RAS_UNDERFLOW_GUARD_EN
        if (occ_r == {OW{1'b0}}) begin
            guarded_op_s.pop = 1'b0;
        end else begin
            guarded_op_s.pop = dec_op_s.pop;
        end
`endif
    end

    // FSM next state and stage register load; a flush drops the accept.
    always_comb begin
        state_next_s = state_r;
        stage_next_s = '0;
        case (state_r)
            RUN: begin
                if (flush_s) begin
                    state_next_s = FLUSH;
                end else if (accept_s) begin
                    state_next_s = RUN;
                    stage_next_s = guarded_op_s;
                end else begin
                    state_next_s = RUN;
                end
            end
            FLUSH: begin
                if (flush_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = RUN;
                end
            end
            default: begin
                state_next_s = RUN;
            end
        endcase
    end

    // Saturating occupancy estimate, updated as each op is staged.
    always_comb begin
        occ_next_s = occ_r;
        case ({stage_next_s.push, stage_next_s.pop})
            2'b10: begin
                if (occ_r != OW'(RAS_ENTRIES)) begin
                    occ_next_s = occ_r + OW'(1);
                end else begin
                    occ_next_s = occ_r;
                end
            end
            2'b01: begin
                if (occ_r != {OW{1'b0}}) begin
                    occ_next_s = occ_r - OW'(1);
                end else begin
                    occ_next_s = occ_r;
                end
            end
            default: begin
                occ_next_s = occ_r;
            end
        endcase
    end

    // In-flight checkpoint count; flushes discard all speculative branches.
    always_comb begin
        inflight_next_s = inflight_r;
        if (flush_s) begin
            inflight_next_s = {IW{1'b0}};
        end else begin
            case ({stage_r.branch_fetched, branch_retire})
                2'b10: begin
                    if (inflight_r != IW'(MAX_IDS)) begin
                        inflight_next_s = inflight_r + IW'(1);
                    end else begin
                        inflight_next_s = inflight_r;
                    end
                end
                2'b01: begin
                    if (inflight_r != {IW{1'b0}}) begin
                        inflight_next_s = inflight_r - IW'(1);
                    end else begin
                        inflight_next_s = inflight_r;
                    end
                end
                default: begin
                    inflight_next_s = inflight_r;
                end
            endcase
        end
    end

    // State, stage and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= RUN;
            stage_r    <= '0;
            inflight_r <= {IW{1'b0}};
            occ_r      <= {OW{1'b0}};
        end else begin
            state_r    <= state_next_s;
            stage_r    <= stage_next_s;
            inflight_r <= inflight_next_s;
            occ_r      <= occ_next_s;
        end
    end

endmodule

// File: doc/ras_ctrl.md
# ras_ctrl

Return-address-stack controller between fetch decode and the `ras` block. It classifies each accepted control-flow instruction into RAS push, pop or pop+push using the RISC-V link-register hint rules, and computes the return address. It registers the resulting operation for one cycle, tracks in-flight speculative branches against the RAS checkpoint FIFO depth, and quiesces RAS traffic for one cycle after a fetch flush.

## Interface
Parameters:
- `RAS_ENTRIES`, 8: RAS depth; power of two, minimum 2.
- `MAX_IDS`, 8: checkpoint FIFO depth in the RAS; sets the in-flight branch limit.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fetch_valid`  in  1  a decoded fetch instruction is presented.
- `fetch_ready`  out  1  this block can accept it; accept = `fetch_valid & fetch_ready`.
- `is_jal`  in  1  instruction is JAL.
- `is_jalr`  in  1  instruction is JALR.
- `is_branch`  in  1  instruction is a speculative control-flow op that needs an RAS checkpoint.
- `is_compressed`  in  1  16-bit encoding.
- `rd_addr`  in  5  destination register.
- `rs1_addr`  in  5  source register.
- `pc`  in  32  instruction PC.
- `branch_retire`  in  1  the oldest checkpointed branch retired.
- `fetch_flush`  in  1  global fetch flush.
- `early_flush`  in  1  early branch flush (RAS adjust).
- `ras_push`  out  1  push request to the RAS.
- `ras_pop`  out  1  pop request to the RAS.
- `ras_new_addr`  out  32  return address pushed.
- `ras_branch_fetched`  out  1  checkpoint push to the RAS.
- `ras_branch_retired`  out  1  checkpoint pop to the RAS; combinational copy of `branch_retire`.

## Operation
- Link register: `x1` or `x5`.
- Classification:
  - JAL, rd link → push.
  - JALR, rd not link, rs1 link → pop.
  - JALR, rd link, rs1 not link → push.
  - JALR, rd link, rs1 link, rd≠rs1 → pop+push.
  - JALR, rd link, rs1 link, rd==rs1 → push.
  - Otherwise → no op.
- Return address: `pc + 2` if compressed, else `pc + 4`, mod 2^32.
- Stage register: on accept, latch `push`, `pop`, `new_addr` and `branch_fetched = is_branch`. With no accept, the stage holds zero ops.
- In-flight counter `inflight`, 0..MAX_IDS:
  - Increments on `ras_branch_fetched` and decrements on `branch_retire`; simultaneous events leave it unchanged.
  - Decrement at 0 is ignored.
  - Cleared on `fetch_flush | early_flush`.
- `fetch_ready = (state==RUN) & (inflight + staged_branch < MAX_IDS)`.
- Occupancy counter `occ`, 0..RAS_ENTRIES:
  - +1 on push, −1 on pop, saturating at both ends; pop+push leaves it unchanged.
  - Not modified by flushes; it is an approximation.
- FSM:
  - RUN: any `fetch_flush` or `early_flush` → FLUSH, and the stage register is cleared.
  - FLUSH: outputs zero, `fetch_ready`=0. Next cycle → RUN unless a flush is still asserted, in which case stay in FLUSH.
- Simultaneous accept and flush: the flush wins and the instruction is dropped.
- `branch_retire` passes through in every state.

## Timing
- Registered path latency: 1 cycle from accept to `ras_push`/`ras_pop`/`ras_branch_fetched`.
- `ras_branch_retired` has 0-cycle latency.
- Reset values:
  - `ras_push`, `ras_pop`, `ras_branch_fetched`, `ras_new_addr` = 0.
  - `inflight` = 0, `occ` = 0, state = RUN.
  - `fetch_ready` = 1 after reset release.
- Reset mid-operation clears all state immediately (asynchronous). No op is emitted on the first edge after release.
- Back-to-back accepts are allowed every cycle in RUN.

## Configuration
- `RAS_UNDERFLOW_GUARD_EN`:
  - Defined: when `occ==0`, a pop is suppressed. Pop+push degrades to a push; a pure pop becomes no op.
  - Undefined: pops always issue; `occ` is still maintained and only observed for debug.

## Structure
- Shared package `cva5_types`:
  - `ras_op_t` struct {push, pop, branch_fetched, new_addr}.
  - `ras_ctrl_state_t` enum {RUN, FLUSH}.
  - Constants `LINK_REG_X1 = 5'd1` and `LINK_REG_X5 = 5'd5`.
- One sub-module, `ras_op_decode`: combinational classification and return address, reused by the stage register.

## Test plan
- JAL rd=x1, pc=0x1000, 32-bit → next cycle `ras_push`=1, `ras_new_addr`=0x1004, `ras_pop`=0.
- JALR rd=x0 rs1=x1 after one push → `ras_pop`=1 only. JALR rd=x5 rs1=x1, compressed, pc=0x2000 → push=1, pop=1, new_addr=0x2002.
- 8 consecutive `is_branch` accepts, no retire, MAX_IDS=8 → `fetch_ready`=0 after the 8th. One `branch_retire` → `fetch_ready`=1 the next cycle.
- Accept and `fetch_flush` in the same cycle → no op emitted, FLUSH for 1 cycle with `fetch_ready`=0, `inflight`=0, then RUN.
- With `RAS_UNDERFLOW_GUARD_EN` and `occ`=0: JALR rd=x0 rs1=x1 → no pop. JALR rd=x1 rs1=x5 → push only.
- Assert `rst_n`=0 while the stage register holds a push → outputs 0 immediately, `fetch_ready`=1 after release.
